hci_core_r_id_tracker: RTL and testbench
========================================

Name: hci_core_r_id_tracker

Overview:
- Parametrised, multi-outstanding successor to the single-entry r_id filter on the HCI core path.
- Captures the request `id` of every granted transaction that will produce a response, and keeps them in an in-order ID queue of depth DEPTH.
- Returns the queued ID on `r_id` when the matching `r_valid` is accepted.
- Sits at any point where the downstream path is in-order with variable latency. Adds outstanding-count, overflow-protection and underflow-error reporting.

Parameters:
- `DEPTH`, 4: maximum outstanding tracked transactions. Must be ≥1.
- `WRITE_RESP`, 0: 1 = writes (`wen`=0) also produce an `r_valid` and are tracked; 0 = only reads (`wen`=1) are tracked.
- `MAX_LATENCY`, 64: cycle limit for the head entry. Used only with the optional feature.
- `HCI_SIZE_tcdm_target`, '0: HCI size struct (`IW`, `DW`, `AW`, `UW`, `EW`, `EHW`) for both interfaces.

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `clear_i`  in  1  synchronous flush of queue and error flags
- `enable_i`  in  1  tracking enable
- `tcdm_target`  hci_core_intf.target  `IW`-sized  upstream side; `id` is captured, `r_id` is driven
- `tcdm_initiator`  hci_core_intf.initiator  same size  downstream side; `id` is tied to '0
- `outstanding_o`  out  $clog2(DEPTH+1)  current queue occupancy
- `err_underflow_o`  out  1  sticky: response accepted while queue empty
- `err_timeout_o`  out  1  sticky: head entry exceeded MAX_LATENCY (optional feature)

Behaviour:
- Passthrough: `add`, `data`, `be`, `wen`, `user`, `ecc`, `r_ready` pass downstream unchanged; `r_data`, `r_user`, `r_opc`, `r_ecc`, `r_valid` pass upstream unchanged.
- ECC handshake signals follow the same replication rule as the existing core filters: if `EHW`>0 they mirror `req`/`gnt`/`r_valid`/`r_ready`; otherwise `ereq`=0, `egnt`=1, `r_evalid`=0, `r_eready`=1.
- Tracked transaction: `target.req & target.gnt & (WRITE_RESP | target.wen)`.
- Push: the `id` of a tracked transaction is written at the tail on the same edge. Only when `enable_i`=1.
- Pop: `initiator.r_valid & target.r_ready` with the queue non-empty advances the head. Only when `enable_i`=1.
- `r_id`: head entry when the queue is non-empty, else '0. Combinational from registered storage; no fall-through.
- Full gating: when `outstanding_o`==DEPTH, `initiator.req`=0 and `target.gnt`=0. There is no same-cycle pop credit, so a full queue stalls one cycle even if a pop occurs.
- Not full: `initiator.req`=`target.req`, `target.gnt`=`initiator.gnt`.
- Simultaneous push and pop: occupancy unchanged, both pointers advance. Pointers wrap modulo DEPTH; DEPTH need not be a power of two.
- Underflow: pop condition with an empty queue sets `err_underflow_o`. Occupancy stays 0, no pointer moves.
- `enable_i`=0: no push or pop, `r_id`='0, full gating still applies, stored state is held.
- `clear_i` has priority over push and pop. Pointers, occupancy and both error flags go to 0 on the next edge, and `req`/`gnt` are ungated from that cycle on.
- Reset values: `outstanding_o`=0, `err_underflow_o`=0, `err_timeout_o`=0, `r_id`=0, pointers 0, storage 0.
- Reset asserted mid-operation: all state is cleared immediately (asynchronous). In-flight downstream responses after reset count as underflow.
- Size asserts on `DW`/`AW`/`UW`/`EW`/`EHW` equality between the two interfaces are non-synthesis only.

Optional Feature:
- Macro `HCI_R_ID_TRACKER_TIMEOUT_EN`.
- Defined: an age counter of width $clog2(MAX_LATENCY+1) runs while the queue is non-empty. It resets to 0 on every pop, on `clear_i`, and when the queue is empty.
- Defined: when the counter reaches MAX_LATENCY, `err_timeout_o` is set sticky and the counter saturates. The flag is cleared only by `clear_i` or reset.
- Not defined: no counter exists and `err_timeout_o` is tied to 0.

Test Plan:
- DEPTH=4, reads with ids 3,7,9 granted on back-to-back cycles, then responses delayed 5 cycles and given one per cycle → `r_id` is 3,7,9 in order; `outstanding_o` goes 1,2,3 then back to 0.
- DEPTH=2, downstream `gnt`=1, three consecutive reads with `r_valid` held 0 → third request sees `initiator.req`=0 and `target.gnt`=0; `outstanding_o`=2 is held.
- Queue at 1 entry, push id 5 and pop on the same cycle → `outstanding_o` stays 1; next `r_id`=5; pointer wrap at DEPTH=3 verified over 10 transactions.
- WRITE_RESP=0: write with id 4, then read with id 6 → only 6 is queued, and the first `r_valid` returns `r_id`=6. With WRITE_RESP=1 the same sequence returns 4 then 6.
- `r_valid`=1 with an empty queue → `err_underflow_o`=1 from the next cycle; `clear_i` pulse → flag 0 and `outstanding_o`=0. Repeat with `clear_i` asserted alongside a push → queue stays empty.
- With `HCI_R_ID_TRACKER_TIMEOUT_EN` and MAX_LATENCY=8: one read granted, no response → `err_timeout_o`=1 exactly 8 cycles after the grant. Without the macro the flag stays 0.

Source files
------------

// File: rtl/hci_core_r_id_tracker_if.sv
// HCI core bus interface and size descriptor used by hci_core_r_id_tracker.
//
// hci_core_r_id_tracker_pkg::hci_size_parameter_t bundles the bus widths
// (IW, DW, AW, UW, EW, EHW).
//
// hci_core_r_id_tracker_if carries one HCI core channel:
//   request  : req, add, wen, data, be, user, id, ecc, ereq, r_ready, r_eready
//   response : gnt, egnt, r_valid, r_evalid, r_data, r_user, r_id, r_opc, r_ecc
// Modports:
//   initiator : drives the request side, samples the response side
//   target    : samples the request side, drives the response side
// Zero-width fields (UW/EW/EHW = 0) are carried as one dead bit.

package hci_core_r_id_tracker_pkg;
  typedef struct packed {
    int unsigned IW;
    int unsigned DW;
    int unsigned AW;
    int unsigned UW;
    int unsigned EW;
    int unsigned EHW;
  } hci_size_parameter_t;
endpackage

interface hci_core_r_id_tracker_if #(
  parameter int unsigned IW  = 8,
  parameter int unsigned DW  = 32,
  parameter int unsigned AW  = 32,
  parameter int unsigned UW  = 1,
  parameter int unsigned EW  = 1,
  parameter int unsigned EHW = 1
);
  localparam int unsigned BW   = (DW >= 8) ? DW / 8 : 1;
  localparam int unsigned UWP  = (UW  > 0) ? UW  : 1;
  localparam int unsigned EWP  = (EW  > 0) ? EW  : 1;
  localparam int unsigned EHWP = (EHW > 0) ? EHW : 1;

  logic            req;
  logic            gnt;
  logic [AW-1:0]   add;
  logic            wen;
  logic [DW-1:0]   data;
  logic [BW-1:0]   be;
  logic            r_ready;
  logic [UWP-1:0]  user;
  logic [IW-1:0]   id;
  logic [EWP-1:0]  ecc;
  logic [EHWP-1:0] ereq;
  logic [EHWP-1:0] r_eready;

  logic [DW-1:0]   r_data;
  logic            r_valid;
  logic [UWP-1:0]  r_user;
  logic [IW-1:0]   r_id;
  logic            r_opc;
  logic [EWP-1:0]  r_ecc;
  logic [EHWP-1:0] egnt;
  logic [EHWP-1:0] r_evalid;

  modport initiator (
    output req, add, wen, data, be, r_ready, user, id, ecc, ereq, r_eready,
    input  gnt, r_data, r_valid, r_user, r_id, r_opc, r_ecc, egnt, r_evalid
  );

  modport target (
    input  req, add, wen, data, be, r_ready, user, id, ecc, ereq, r_eready,
    output gnt, r_data, r_valid, r_user, r_id, r_opc, r_ecc, egnt, r_evalid
  );
endinterface

// File: rtl/hci_core_r_id_tracker.sv
// hci_core_r_id_tracker: in-order, multi-outstanding response-ID tracker for
// the HCI core path.
//
// Every granted request that will produce a response has its id pushed into a
// DEPTH-entry circular queue. When a response is accepted upstream, the head
// entry is returned on r_id and popped. All other fields pass through
// unchanged. Downstream id is tied to zero.
//
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   clear_i          synchronous flush of the queue and error flags
//   enable_i         enables push/pop and r_id drive
//   tcdm_target      upstream side (id captured, r_id driven)
//   tcdm_initiator   downstream side
//   outstanding_o    queue occupancy
//   err_underflow_o  sticky: response accepted with an empty queue
//   err_timeout_o    sticky: head entry older than MAX_LATENCY cycles
//
// Optional feature macro HCI_R_ID_TRACKER_TIMEOUT_EN adds the head-age counter
// behind err_timeout_o. Without it the flag is tied to 0.

module hci_core_r_id_tracker
  import hci_core_r_id_tracker_pkg::*;
#(
  parameter int unsigned         DEPTH                = 4,
  parameter bit                  WRITE_RESP           = 1'b0,
  parameter int unsigned         MAX_LATENCY          = 64,
  parameter hci_size_parameter_t HCI_SIZE_tcdm_target = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       enable_i,
  hci_core_r_id_tracker_if.target    tcdm_target,
  hci_core_r_id_tracker_if.initiator tcdm_initiator,
  output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
  output logic                       err_underflow_o,
  output logic                       err_timeout_o
);

  localparam int unsigned IW  = HCI_SIZE_tcdm_target.IW;
  localparam int unsigned EHW = HCI_SIZE_tcdm_target.EHW;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifndef SYNTHESIS
  if (DEPTH < 1) begin : g_chk_depth
    $error("DEPTH must be >= 1");
  end
  if (MAX_LATENCY < 1) begin : g_chk_lat
    $error("MAX_LATENCY must be >= 1");
  end
  if (tcdm_target.IW != IW || tcdm_target.EHW != EHW) begin : g_chk_size
    $error("tcdm_target size does not match HCI_SIZE_tcdm_target");
  end
  if (tcdm_target.DW  != tcdm_initiator.DW  || tcdm_target.AW != tcdm_initiator.AW ||
      tcdm_target.UW  != tcdm_initiator.UW  || tcdm_target.EW != tcdm_initiator.EW ||
      tcdm_target.EHW != tcdm_initiator.EHW) begin : g_chk_intf
    $error("tcdm_target and tcdm_initiator sizes differ");
  end
`endif

  logic [IW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          err_uf_q;

  logic empty, full, gnt_up, req_dn;
  logic push, resp, pop, uf_set;

  assign empty = (cnt_q == '0);
  // No same-cycle pop credit: a full queue blocks the request even if the
  // head is being retired on this edge.
  assign full  = (cnt_q == CW'(DEPTH));

  assign req_dn = tcdm_target.req    & ~full;
  assign gnt_up = tcdm_initiator.gnt & ~full;

  assign push   = enable_i & tcdm_target.req & gnt_up & (WRITE_RESP | tcdm_target.wen);
  assign resp   = enable_i & tcdm_initiator.r_valid & tcdm_target.r_ready;
  assign pop    = resp & ~empty;
  assign uf_set = resp &  empty;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_uf_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_uf_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= tcdm_target.id;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      if (uf_set) err_uf_q <= 1'b1;
    end
  end

  assign outstanding_o   = cnt_q;
  assign err_underflow_o = err_uf_q;

`ifdef HCI_R_ID_TRACKER_TIMEOUT_EN
  localparam int unsigned AGW = $clog2(MAX_LATENCY + 1);
  logic [AGW-1:0] age_q;
  logic           err_to_q;

  // Age of the current head; restarts whenever the head changes or the queue
  // drains, saturates at MAX_LATENCY.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      age_q    <= '0;
      err_to_q <= 1'b0;
    end else if (clear_i) begin
      age_q    <= '0;
      err_to_q <= 1'b0;
    end else if (pop || empty) begin
      age_q <= '0;
    end else if (age_q != AGW'(MAX_LATENCY)) begin
      age_q <= age_q + 1'b1;
      if (age_q == AGW'(MAX_LATENCY - 1)) err_to_q <= 1'b1;
    end
  end

  assign err_timeout_o = err_to_q;
`else
  assign err_timeout_o = 1'b0;
`endif

  // Downstream request path
  assign tcdm_initiator.req     = req_dn;
  assign tcdm_initiator.add     = tcdm_target.add;
  assign tcdm_initiator.wen     = tcdm_target.wen;
  assign tcdm_initiator.data    = tcdm_target.data;
  assign tcdm_initiator.be      = tcdm_target.be;
  assign tcdm_initiator.user    = tcdm_target.user;
  assign tcdm_initiator.ecc     = tcdm_target.ecc;
  assign tcdm_initiator.id      = '0;
  assign tcdm_initiator.r_ready = tcdm_target.r_ready;

  // Upstream response path
  assign tcdm_target.gnt     = gnt_up;
  assign tcdm_target.r_data  = tcdm_initiator.r_data;
  assign tcdm_target.r_valid = tcdm_initiator.r_valid;
  assign tcdm_target.r_user  = tcdm_initiator.r_user;
  assign tcdm_target.r_opc   = tcdm_initiator.r_opc;
  assign tcdm_target.r_ecc   = tcdm_initiator.r_ecc;
  assign tcdm_target.r_id    = (enable_i && !empty) ? mem_q[rd_ptr_q] : '0;

  // ECC handshake copies follow the (gated) main handshake
  if (EHW > 0) begin : g_ecc
    assign tcdm_initiator.ereq     = {EHW{req_dn}};
    assign tcdm_initiator.r_eready = {EHW{tcdm_target.r_ready}};
    assign tcdm_target.egnt        = {EHW{gnt_up}};
    assign tcdm_target.r_evalid    = {EHW{tcdm_initiator.r_valid}};
  end else begin : g_no_ecc
    assign tcdm_initiator.ereq     = '0;
    assign tcdm_initiator.r_eready = '1;
    assign tcdm_target.egnt        = '1;
    assign tcdm_target.r_evalid    = '0;
  end

  // Inputs deliberately ignored: upstream ECC handshake copies and the
  // downstream response id (order is recovered from the queue instead).
  logic unused_in;
  assign unused_in = ^{tcdm_target.ereq, tcdm_target.r_eready,
                       tcdm_initiator.egnt, tcdm_initiator.r_evalid,
                       tcdm_initiator.r_id};

endmodule

// File: tb/tb_hci_core_r_id_tracker.sv
// Bench for hci_core_r_id_tracker: two instances share one stimulus stream
// (DEPTH=3/reads only, DEPTH=2/writes tracked). The stimulus process records
// each accepted tracked id in a per-instance expected queue; a monitor samples
// mid-cycle, compares gating, passthrough, occupancy, flags and r_id against a
// queue-level model, and pops the queue on each accepted response.

module tb_hci_core_r_id_tracker;
  import hci_core_r_id_tracker_pkg::*;

  localparam int NK   = 2;
  localparam int MAXL = 8;
  localparam hci_size_parameter_t SZ = '{IW: 4, DW: 32, AW: 16, UW: 2, EW: 7, EHW: 1};

`ifdef HCI_R_ID_TRACKER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  function automatic int dep(input int k);
    return (k == 0) ? 3 : 2;
  endfunction
  function automatic bit wr(input int k);
    return (k == 1);
  endfunction

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus
  logic        req = 0, wen = 0, gnt_d = 0, r_valid = 0, r_ready = 0, en = 0, clr = 0;
  logic [3:0]  id = '0;
  logic [15:0] add = '0;
  logic [31:0] data = '0, r_data = '0;
  logic [3:0]  be = '0;
  logic [1:0]  user = '0, r_user = '0;
  logic [6:0]  ecc = '0, r_ecc = '0;
  logic        r_opc = 0;

  // per-instance observations
  logic [NK-1:0] o_ireq, o_tgnt, o_ereq, o_egnt, o_rv, o_rr, o_uf, o_to;
  int            o_occ   [NK];
  logic [3:0]    o_rid   [NK];
  logic [3:0]    o_iid   [NK];
  logic [15:0]   o_add   [NK];
  logic [31:0]   o_rdata [NK];

  for (genvar g = 0; g < NK; g++) begin : g_dut
    localparam int unsigned D  = (g == 0) ? 3 : 2;
    localparam bit          WR = (g == 1);
    hci_core_r_id_tracker_if #(.IW(4), .DW(32), .AW(16), .UW(2), .EW(7), .EHW(1)) tgt ();
    hci_core_r_id_tracker_if #(.IW(4), .DW(32), .AW(16), .UW(2), .EW(7), .EHW(1)) ini ();
    logic [$clog2(D+1)-1:0] occ;
    logic uf, to;

    assign tgt.req = req;   assign tgt.add = add;   assign tgt.wen = wen;
    assign tgt.data = data; assign tgt.be = be;     assign tgt.user = user;
    assign tgt.id = id;     assign tgt.ecc = ecc;   assign tgt.r_ready = r_ready;
    assign tgt.ereq = '0;   assign tgt.r_eready = '0;
    assign ini.gnt = gnt_d; assign ini.r_data = r_data; assign ini.r_valid = r_valid;
    assign ini.r_user = r_user; assign ini.r_id = 4'hf; assign ini.r_opc = r_opc;
    assign ini.r_ecc = r_ecc;   assign ini.egnt = '0;   assign ini.r_evalid = '0;

    hci_core_r_id_tracker #(
      .DEPTH(D), .WRITE_RESP(WR), .MAX_LATENCY(MAXL), .HCI_SIZE_tcdm_target(SZ)
    ) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .enable_i(en),
      .tcdm_target(tgt), .tcdm_initiator(ini),
      .outstanding_o(occ), .err_underflow_o(uf), .err_timeout_o(to)
    );

    assign o_ireq[g] = ini.req;      assign o_tgnt[g] = tgt.gnt;
    assign o_ereq[g] = ini.ereq[0];  assign o_egnt[g] = tgt.egnt[0];
    assign o_rv[g]   = tgt.r_valid;  assign o_rr[g]   = ini.r_ready;
    assign o_uf[g]   = uf;           assign o_to[g]   = to;
    assign o_occ[g]  = int'(occ);    assign o_rid[g]  = tgt.r_id;
    assign o_iid[g]  = ini.id;       assign o_add[g]  = ini.add;
    assign o_rdata[g] = tgt.r_data;
  end

  // reference model state
  logic [3:0] exp_q [NK][$];
  bit         m_uf [NK];
  bit         m_to [NK];
  int         m_since [NK];   // cycle at which the current head became head
  int         cyc_n = 0;
  int         total = 0, bad = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input int k, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  // monitor: mid-cycle, after stimulus settles, before the next edge
  always @(negedge clk) begin
    int sz;
    bit full, resp;
    logic [3:0] hd;
    #1;
    if (rst_n) begin
      for (int k = 0; k < NK; k++) begin
        sz   = exp_q[k].size();
        full = (sz == dep(k));
        hd   = (sz > 0) ? exp_q[k][0] : 4'd0;
        if (sz > 0 && (cyc_n - m_since[k]) >= MAXL) m_to[k] = 1'b1;

        chk("occ",   k, o_occ[k],  sz);
        chk("ireq",  k, o_ireq[k], req & ~full);
        chk("tgnt",  k, o_tgnt[k], gnt_d & ~full);
        chk("ereq",  k, o_ereq[k], req & ~full);
        chk("egnt",  k, o_egnt[k], gnt_d & ~full);
        chk("uflow", k, o_uf[k],   m_uf[k]);
        chk("tmo",   k, o_to[k],   m_to[k] & TO_EN);
        chk("rid",   k, o_rid[k],  (en && sz > 0) ? hd : 4'd0);
        chk("pass",  k, {o_add[k], o_rdata[k], o_rv[k], o_rr[k], o_iid[k]},
                        {add, r_data, r_valid, r_ready, 4'd0});

        resp = en & r_valid & r_ready;
        if (clr) begin
          exp_q[k].delete();
          m_uf[k] = 1'b0;
          m_to[k] = 1'b0;
        end else if (resp) begin
          if (sz > 0) begin
            chk("resp_id", k, o_rid[k], hd);
            void'(exp_q[k].pop_front());
            m_since[k] = cyc_n + 1;
          end else begin
            m_uf[k] = 1'b1;
          end
        end
      end
    end
  end

  // one cycle of stimulus; tracked grants are recorded after the edge
  task automatic cyc(input bit rq, input bit wn, input logic [3:0] i, input bit g,
                     input bit rv, input bit rr, input bit e, input bit c);
    bit wp [NK];
    @(negedge clk);
    req = rq; wen = wn; id = i; gnt_d = g; r_valid = rv; r_ready = rr; en = e; clr = c;
    add = 16'($urandom); data = $urandom; r_data = $urandom; be = 4'($urandom);
    user = 2'($urandom); r_user = 2'($urandom); ecc = 7'($urandom);
    r_ecc = 7'($urandom); r_opc = 1'($urandom);
    for (int k = 0; k < NK; k++)
      wp[k] = e & ~c & rq & g & (exp_q[k].size() < dep(k)) & (wr(k) | wn);
    @(posedge clk); #1;
    for (int k = 0; k < NK; k++)
      if (wp[k]) begin
        if (exp_q[k].size() == 0) m_since[k] = cyc_n;
        exp_q[k].push_back(i);
      end
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cyc(0, 0, 4'd0, 0, 0, 0, 1, 0);
  endtask

  task automatic resp_n(input int n);
    for (int j = 0; j < n; j++) cyc(0, 0, 4'd0, 0, 1, 1, 1, 0);
  endtask

  task automatic reset_check();
    #1;
    for (int k = 0; k < NK; k++) begin
      chk("rst_occ", k, o_occ[k], 0);
      chk("rst_flg", k, {o_uf[k], o_to[k]}, 2'b00);
      chk("rst_rid", k, o_rid[k], 4'd0);
      exp_q[k].delete();
      m_uf[k] = 1'b0;
      m_to[k] = 1'b0;
    end
  endtask

  task automatic rand_run(input int n);
    for (int j = 0; j < n; j++)
      cyc($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, 4'($urandom),
          $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 8,
          $urandom_range(0, 19) != 0, $urandom_range(0, 49) == 0);
  endtask

  initial begin
    #2 reset_check();
    @(negedge clk); #2 rst_n = 1'b1;

    // three back-to-back reads, late in-order responses
    cyc(1, 1, 4'd3, 1, 0, 0, 1, 0);
    cyc(1, 1, 4'd7, 1, 0, 0, 1, 0);
    cyc(1, 1, 4'd9, 1, 0, 0, 1, 0);
    idle(5);
    resp_n(3);
    idle(1);

    // write then read: only the read is tracked when writes give no response
    cyc(1, 0, 4'd4, 1, 0, 0, 1, 0);
    cyc(1, 1, 4'd6, 1, 0, 0, 1, 0);
    resp_n(2);

    // push and pop in the same cycle, then wrap over many transactions
    cyc(1, 1, 4'd1, 1, 0, 0, 1, 0);
    cyc(1, 1, 4'd5, 1, 1, 1, 1, 0);
    resp_n(1);
    for (int j = 0; j < 10; j++) cyc(1, 1, 4'(j), 1, j > 0, 1, 1, 0);
    resp_n(2);

    // underflow, clear, clear racing a push
    resp_n(1);
    idle(1);
    cyc(0, 0, 4'd0, 0, 0, 0, 1, 1);
    cyc(1, 1, 4'd8, 1, 0, 0, 1, 1);
    idle(1);

    // disabled: no push, no pop, r_id forced 0
    cyc(1, 1, 4'd2, 1, 0, 0, 1, 0);
    cyc(1, 1, 4'd3, 1, 1, 1, 0, 0);
    idle(1);
    resp_n(1);

    // one unanswered read ages past MAX_LATENCY
    cyc(1, 1, 4'd1, 1, 0, 0, 1, 0);
    idle(MAXL + 3);
    cyc(0, 0, 4'd0, 0, 0, 0, 1, 1);
    idle(1);

    rand_run(3000);

    // asynchronous reset mid-traffic, then a stale response
    idle(0);
    cyc(1, 1, 4'd12, 1, 0, 0, 1, 0);
    cyc(0, 0, 4'd0, 0, 0, 0, 1, 0);
    @(negedge clk); #2 rst_n = 1'b0;
    reset_check();
    @(negedge clk); #2 rst_n = 1'b1;
    resp_n(1);
    idle(1);

    rand_run(500);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
